vga_scan: RTL and testbench
===========================

VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 SHALL have parameter BUF1_START, default 16'h0000: word base of VGA line buffer 1.
REQ-002 SHALL have parameter BUF2_START, default 16'h1400: word base of VGA line buffer 2 (5120 words after BUF1).
REQ-003 SHALL have parameter FONT_ROWS, default 16: pixel lines per buffer band; fixed at 16.
REQ-004 SHALL have port CLK50MHz  input  1  system clock, 50 MHz; two clocks per pixel.
REQ-005 SHALL have port RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port XCoord  output  11  current horizontal counter hc, 0..799.
REQ-007 SHALL have port YCoord  output  11  current vertical counter vc, 0..524.
REQ-008 SHALL have port RADDR_VGA  output  16  word read address into the VGA buffer RAM.
REQ-009 SHALL have port MR_VGA_ON  output  1  read enable, high while a fetch address is valid.
REQ-010 SHALL have port DATA_OUT_VGA  input  16  RAM read data {left pixel[15:8], right pixel[7:0]}, RRRGGGBB.
REQ-011 SHALL have port VGA_R  output  3  red.
REQ-012 SHALL have port VGA_G  output  3  green.
REQ-013 SHALL have port VGA_B  output  2  blue.
REQ-014 SHALL have port HSYNC  output  1  horizontal sync, active low.
REQ-015 SHALL have port VSYNC  output  1  vertical sync, active low.
REQ-016 SHALL have port FRAME_TICK  output  1  one-clock pulse at end of frame.

Function
REQ-017 SHALL keep phase bit p toggling every clock; hc advances when p==1; hc wraps 799->0 and vc advances; vc wraps 524->0.
REQ-018 SHALL drive XCoord=hc, YCoord=vc directly from the counter registers.
REQ-019 SHALL treat active video as hc<640 and vc<480; everything else is blanking.
REQ-020 SHALL select the read buffer by vc[4]: 0 -> BUF1_START, 1 -> BUF2_START (the opposite of the band the writer fills).
REQ-021 SHALL, on the edge where hc is even, p==0 and position is active, register RADDR_VGA = base + ((vc[3:0]*640 + hc) >> 1) and assert MR_VGA_ON; outside active video MR_VGA_ON SHALL be 0 and RADDR_VGA SHALL hold.
REQ-022 SHALL assume 1-clock synchronous RAM read latency and capture DATA_OUT_VGA into a word register exactly 2 clocks after the RADDR_VGA update edge.
REQ-023 SHALL output the captured high byte for 2 clocks, then the low byte for 2 clocks, as {VGA_R,VGA_G,VGA_B}.
REQ-024 SHALL present colour, HSYNC and VSYNC for counter position (hc,vc) exactly 4 clocks after the counters first hold that position (fixed pipeline, same delay on all three).
REQ-025 SHALL force colour to 0 for blanking positions, regardless of RAM data.
REQ-026 SHALL assert HSYNC low for hc 656..751 and VSYNC low for vc 490..491, both after the 4-clock delay.
REQ-027 SHALL pulse FRAME_TICK for one clock on the edge where hc==799, vc==524, p==1 (undelayed); period 840000 clocks.
REQ-028 SHALL use 11-bit counters; address arithmetic SHALL be 16-bit, truncating any carry.

Reset
REQ-029 SHALL, while RST_N==0, force hc=0, vc=0, p=0, RADDR_VGA=BUF1_START, MR_VGA_ON=0, colour=0, HSYNC=1, VSYNC=1, FRAME_TICK=0, and clear the delay pipeline.
REQ-030 SHALL, on reset mid-line, abandon the line; the first clock after release SHALL restart at (0,0) with p=0, and the pipeline SHALL emit blank, HSYNC=1 and VSYNC=1 for its first 4 clocks.

Verification
REQ-031 Reset release, RAM returns 16'hE01C -> RADDR_VGA=16'h0000 after first fetch edge; colour 8'hE0 for clocks 4-5, 8'h1C for clocks 6-7.
REQ-032 Run to vc=16, hc=0 -> RADDR_VGA=16'h1400; vc=17, hc=2 -> 16'h1541.
REQ-033 Full line -> HSYNC low for exactly 192 clocks, starting 4 clocks after hc reaches 656; MR_VGA_ON pulses 320 times per active line.
REQ-034 Full frame, RAM drives 16'hFFFF -> colour 0 whenever delayed position is outside 640x480; VSYNC low for exactly 3200 clocks.
REQ-035 Two frames -> FRAME_TICK pulses exactly once per 840000 clocks.
REQ-036 Assert RST_N at hc=300, vc=100 for 3 clocks -> all outputs at reset values immediately (asynchronous), restart at (0,0) after release.

Source files
------------

// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 VGA timing, line-buffer fetch and 4-clock colour/sync pipeline.
// Two clocks per pixel; each RAM word holds two pixels {left, right}.
module vga_scan #(
  parameter logic [15:0] BUF1_START = 16'h0000,
  parameter logic [15:0] BUF2_START = 16'h1400,
  parameter int          FONT_ROWS  = 16
) (
  input  logic        CLK50MHz,
  input  logic        RST_N,
  output logic [10:0] XCoord,
  output logic [10:0] YCoord,
  output logic [15:0] RADDR_VGA,
  output logic        MR_VGA_ON,
  input  logic [15:0] DATA_OUT_VGA,
  output logic [2:0]  VGA_R,
  output logic [2:0]  VGA_G,
  output logic [1:0]  VGA_B,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        FRAME_TICK
);
  localparam int ROW_BITS = $clog2(FONT_ROWS);
  logic p;
  logic [10:0] hc, vc;
  logic active, last_h, last_v, fetch, fetch_d;
  logic [15:0] lin, base, word;
  logic [3:0] cur;
  logic [2:0][3:0] pipe;
  assign XCoord = hc;
  assign YCoord = vc;
  always_comb begin
    active = hc < 11'd640 && vc < 11'd480;
    last_h = hc == 11'd799;
    last_v = vc == 11'd524;
    fetch  = !p && !hc[0] && active;
    lin    = 16'(vc[ROW_BITS-1:0]) * 16'd640 + 16'(hc);
    base   = vc[ROW_BITS] ? BUF2_START : BUF1_START;
    // {active, hsync, vsync, byte select} for the position currently held
    cur    = {active, !(hc >= 11'd656 && hc <= 11'd751), !(vc >= 11'd490 && vc <= 11'd491), hc[0]};
  end
  always_ff @(posedge CLK50MHz or negedge RST_N)
    if (!RST_N) begin
      p  <= 1'b0;
      hc <= '0;
      vc <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      p <= ~p;
      FRAME_TICK <= p && last_h && last_v;
      if (p) begin
        hc <= last_h ? 11'd0 : hc + 11'd1;
        if (last_h) vc <= last_v ? 11'd0 : vc + 11'd1;
      end
    end
  always_ff @(posedge CLK50MHz or negedge RST_N)
    if (!RST_N) begin
      RADDR_VGA <= BUF1_START;
      MR_VGA_ON <= 1'b0;
      fetch_d   <= 1'b0;
      word      <= '0;
    end else begin
      MR_VGA_ON <= fetch;
      fetch_d   <= MR_VGA_ON;
      if (fetch) RADDR_VGA <= base + (lin >> 1);
      if (fetch_d) word <= DATA_OUT_VGA;
    end
  // three stages here plus the output register give the 4-clock delay
  always_ff @(posedge CLK50MHz or negedge RST_N)
    if (!RST_N) begin
      pipe  <= {3{4'b0110}};
      {VGA_R, VGA_G, VGA_B} <= 8'd0;
      HSYNC <= 1'b1;
      VSYNC <= 1'b1;
    end else begin
      pipe  <= {pipe[1:0], cur};
      {VGA_R, VGA_G, VGA_B} <= pipe[2][3] ? (pipe[2][0] ? word[7:0] : word[15:8]) : 8'd0;
      HSYNC <= pipe[2][2];
      VSYNC <= pipe[2][1];
    end
endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed checks of fetch timing, pixel pipeline, syncs and async reset.
module tb_vga_scan;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] ram;
  logic [10:0] xc, yc;
  logic [15:0] raddr;
  logic mr, hs, vs, ft;
  logic [2:0] r, g;
  logic [1:0] b;
  wire [7:0] colour = {r, g, b};
  int checks = 0, passed = 0;
  int mr_cnt = 0, hs_cnt = 0, hs_first = 0, nz_cnt = 0, blank_bad = 0, ft_cnt = 0;

  vga_scan dut (
    .CLK50MHz(clk), .RST_N(rst_n), .XCoord(xc), .YCoord(yc),
    .RADDR_VGA(raddr), .MR_VGA_ON(mr), .DATA_OUT_VGA(ram),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .HSYNC(hs), .VSYNC(vs), .FRAME_TICK(ft)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, 32'(xc), 32'd0);
    check({tag, "_y"}, 32'(yc), 32'd0);
    check({tag, "_raddr"}, 32'(raddr), 32'h0000);
    check({tag, "_mr"}, 32'(mr), 32'd0);
    check({tag, "_colour"}, 32'(colour), 32'd0);
    check({tag, "_hsync"}, 32'(hs), 32'd1);
    check({tag, "_vsync"}, 32'(vs), 32'd1);
    check({tag, "_tick"}, 32'(ft), 32'd0);
  endtask

  initial begin
    ram = 16'hE01C;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    for (int k = 1; k <= 1608; k++) begin
      @(negedge clk);
      if (k <= 1600 && mr) mr_cnt++;
      if (!hs) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = k;
      end
      if (k <= 1603 && colour != 8'd0) nz_cnt++;
      if (k >= 1284 && k <= 1603 && colour != 8'd0) blank_bad++;
      case (k)
        1: begin
          check("k1_x", 32'(xc), 32'd0);
          check("k1_mr", 32'(mr), 32'd1);
          check("k1_raddr", 32'(raddr), 32'h0000);
          check("k1_colour", 32'(colour), 32'd0);
        end
        2: begin
          check("k2_mr", 32'(mr), 32'd0);
          check("k2_x", 32'(xc), 32'd1);
        end
        3: check("k3_colour", 32'(colour), 32'd0);
        4: begin
          check("k4_colour", 32'(colour), 32'hE0);
          check("k4_x", 32'(xc), 32'd2);
        end
        5: begin
          check("k5_colour", 32'(colour), 32'hE0);
          check("k5_mr", 32'(mr), 32'd1);
          check("k5_raddr", 32'(raddr), 32'h0001);
        end
        6: check("k6_colour", 32'(colour), 32'h1C);
        7: check("k7_colour", 32'(colour), 32'h1C);
        8: check("k8_colour", 32'(colour), 32'hE0);
        1283: check("last_pixel", 32'(colour), 32'h1C);
        1284: check("first_blank", 32'(colour), 32'd0);
        1315: check("hsync_pre", 32'(hs), 32'd1);
        1600: begin
          check("wrap_x", 32'(xc), 32'd0);
          check("wrap_y", 32'(yc), 32'd1);
        end
        default: ;
      endcase
    end
    check("mr_pulses", 32'(mr_cnt), 32'd320);
    check("hsync_len", 32'(hs_cnt), 32'd192);
    check("hsync_start", 32'(hs_first), 32'd1316);
    check("active_clocks", 32'(nz_cnt), 32'd1280);
    check("blank_colour", 32'(blank_bad), 32'd0);
    ram = 16'hFFFF;
    for (int k = 1609; k <= 27800; k++) begin
      @(negedge clk);
      if (ft) ft_cnt++;
      case (k)
        25601: begin
          check("band2_raddr", 32'(raddr), 32'h1400);
          check("band2_y", 32'(yc), 32'd16);
          check("band2_mr", 32'(mr), 32'd1);
        end
        25610: check("ff_active", 32'(colour), 32'hFF);
        26890: check("ff_blank", 32'(colour), 32'd0);
        27201: check("v17_h0_raddr", 32'(raddr), 32'h1540);
        27205: begin
          check("v17_h2_raddr", 32'(raddr), 32'h1541);
          check("v17_h2_x", 32'(xc), 32'd2);
          check("v17_h2_y", 32'(yc), 32'd17);
        end
        27800: check("pre_reset_x", 32'(xc), 32'd300);
        default: ;
      endcase
    end
    check("no_frame_tick", 32'(ft_cnt), 32'd0);
    #3 rst_n = 1'b0;
    #2 check_reset("async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          check("rs1_x", 32'(xc), 32'd0);
          check("rs1_y", 32'(yc), 32'd0);
          check("rs1_mr", 32'(mr), 32'd1);
          check("rs1_raddr", 32'(raddr), 32'h0000);
        end
        3: begin
          check("rs3_colour", 32'(colour), 32'd0);
          check("rs3_hsync", 32'(hs), 32'd1);
        end
        4: check("rs4_colour", 32'(colour), 32'hFF);
        default: ;
      endcase
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
